cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Result-broadcast (common data bus) arbiter between the execution units and the reservation station.
- Each cycle, up to 2 of UNITS requesting units get a writeback port, round-robin.
- Granted results are registered onto the broadcast ports.
- A one-cycle per-register ready pulse vector is generated; this vector drives the reservation station's ready-register input.

Parameters:
UNITS, 5, number of requesting execution units (asb1, asb2, logic, load, store order); 2..8 supported
XLEN, 32, result data width
RBITS, 6, physical register index width; ready vector width is 2**RBITS

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst  in  1  synchronous, active-high reset
i_flush  in  1  pipeline flush; discards this cycle's requests and in-flight broadcasts
i_req_valid  in  UNITS  unit u has a completed result to broadcast
i_req_rd  in  RBITS*UNITS  destination register of unit u, slice [u*RBITS +: RBITS]
i_req_data  in  XLEN*UNITS  result of unit u, slice [u*XLEN +: XLEN]
o_req_ready  out  UNITS  combinational; request of unit u consumed this cycle
o_wb_valid  out  2  broadcast port p carries a result
o_wb_rd  out  2*RBITS  destination register per port
o_wb_data  out  2*XLEN  result per port
o_wb_unit  out  6  source unit index per port, 3 bits each
o_rdy_regs  out  2**RBITS  one-cycle pulse; bit r set when register r was broadcast

Behaviour:
- Reset (i_rst high at an edge):
  - o_wb_valid=0, o_wb_rd=0, o_wb_data=0, o_wb_unit=0, o_rdy_regs=0.
  - rr_ptr=0.
  - Reset mid-operation drops all pending grants; nothing from the reset cycle appears later.
- Handshake:
  - Request u transfers in cycle N iff i_req_valid[u] && o_req_ready[u] at edge N.
  - Units hold valid, rd and data stable until ready.
  - o_req_ready never asserts without i_req_valid.
  - o_req_ready is 0 for all units during i_rst or i_flush.
- rd==0 requests:
  - Always accepted: o_req_ready=1 the same cycle.
  - They consume no port, produce no broadcast, set no o_rdy_regs bit, and do not affect rr_ptr.
- Arbitration for rd!=0 requests:
  - Scan unit indices circularly from rr_ptr: rr_ptr, rr_ptr+1, ... mod UNITS.
  - Port 0 is granted to the first valid request found; port 1 to the second.
  - At most 2 grants per cycle. Remaining requesters see ready=0.
- Pointer update:
  - If any port is granted: rr_ptr <= (index of last granted unit + 1) mod UNITS.
  - Otherwise rr_ptr is unchanged.
  - rr_ptr is unchanged during flush.
  - Fairness: a continuously valid requester is granted within ceil((UNITS-1)/2) cycles; 2 cycles for UNITS=5.
- Latency:
  - A grant at edge N produces o_wb_valid[p], o_wb_rd, o_wb_data, o_wb_unit registered and visible from edge N to N+1, for exactly one cycle.
  - o_rdy_regs[rd] is set in the same cycle as the broadcast.
  - Ungranted port: o_wb_valid[p]=0. o_wb_rd/o_wb_data/o_wb_unit hold their last value and are don't-care.
  - o_rdy_regs = OR of the one-hot decode of each valid port's rd.
- Same rd on both ports:
  - Both broadcasts occur; the single o_rdy_regs bit is set.
  - No error is flagged.
- i_flush at edge N:
  - No grants at edge N.
  - Next cycle: o_wb_valid=0 and o_rdy_regs=0.
  - Broadcasts already visible in cycle N are unaffected.
- Width rules:
  - o_wb_unit is zero-extended unit index.
  - rr_ptr is ceil(log2(UNITS)) bits; wraps UNITS-1 to 0 and never holds a value >= UNITS.
- No internal buffering beyond the output register. Back-pressure is entirely through o_req_ready.

Test Plan:
- Reset then idle:
  - i_rst=1 for 2 cycles, then requests 0.
  - Expect o_wb_valid=00, o_rdy_regs=0, o_req_ready=0 every cycle.
- Single request:
  - Unit 2 valid, rd=17, data=0xDEADBEEF at edge N.
  - Expect o_req_ready=00100 at N.
  - At N+1: o_wb_valid=01, port0 rd=17, data=0xDEADBEEF, unit=2, o_rdy_regs has only bit 17 set.
  - At N+2: o_rdy_regs=0.
- All 5 units valid continuously, rd=u+1:
  - Expect grants {0,1}, {2,3}, {4,0}, {1,2} in consecutive cycles.
  - Expect rr_ptr values 0→2→4→1→3.
  - No unit waits more than 2 cycles.
- rd==0 mixing:
  - Units 0 and 1 valid with rd=0; unit 3 valid with rd=9.
  - Expect ready=01011.
  - Next cycle: only port0 valid, rd=9; o_rdy_regs bit 9 only.
- Flush and reset mid-operation:
  - All units valid; i_flush=1 at edge N.
  - Expect ready=0 at N, o_wb_valid=00 at N+1, rr_ptr unchanged.
  - Repeat with i_rst=1 in place of i_flush: outputs zero at N+1 and rr_ptr=0.
- Duplicate rd:
  - Units 1 and 4 valid, both rd=40, rr_ptr=0.
  - Expect port0 unit=1 and port1 unit=4, both rd=40.
  - o_rdy_regs = bit 40 only; rr_ptr becomes 0 (wrap from 4).

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants up to two round-robin writeback ports per cycle
// and registers the winners onto the broadcast ports with a matching ready-pulse vector.
module cdb_arbiter #(
    parameter int UNITS = 5,
    parameter int XLEN  = 32,
    parameter int RBITS = 6
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic [UNITS-1:0]       i_req_valid,
    input  logic [RBITS*UNITS-1:0] i_req_rd,
    input  logic [XLEN*UNITS-1:0]  i_req_data,
    output logic [UNITS-1:0]       o_req_ready,
    output logic [1:0]             o_wb_valid,
    output logic [2*RBITS-1:0]     o_wb_rd,
    output logic [2*XLEN-1:0]      o_wb_data,
    output logic [5:0]             o_wb_unit,
    output logic [2**RBITS-1:0]    o_rdy_regs
);

    localparam int PW = (UNITS > 1) ? $clog2(UNITS) : 1;

    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       next_ptr;
    logic [2:0]          scan_u    [UNITS];
    logic [1:0]          gnt_valid;
    logic [2:0]          gnt_unit  [2];
    logic [RBITS-1:0]    gnt_rd    [2];
    logic [XLEN-1:0]     gnt_data  [2];
    logic [2:0]          last_unit;
    logic [2**RBITS-1:0] next_rdy;

    function automatic int wrap_add(input int a, input int b);
        int s;
        s = a + b;
        if (s >= UNITS) s = s - UNITS;
        return s;
    endfunction

    always_comb begin
        for (int k = 0; k < UNITS; k++) begin
            scan_u[k] = 3'(wrap_add(int'(rr_ptr), k));
        end
    end

    // rd==0 results carry nothing to broadcast, so they are acknowledged without taking a port
    always_comb begin
        o_req_ready = '0;
        gnt_valid   = '0;
        for (int p = 0; p < 2; p++) begin
            gnt_unit[p] = '0;
            gnt_rd[p]   = '0;
            gnt_data[p] = '0;
        end
        if (!i_rst && !i_flush) begin
            for (int k = 0; k < UNITS; k++) begin
                if (i_req_valid[int'(scan_u[k])]) begin
                    if (i_req_rd[int'(scan_u[k])*RBITS +: RBITS] == '0) begin
                        o_req_ready[int'(scan_u[k])] = 1'b1;
                    end else if (!gnt_valid[1]) begin
                        o_req_ready[int'(scan_u[k])] = 1'b1;
                        if (!gnt_valid[0]) begin
                            gnt_valid[0] = 1'b1;
                            gnt_unit[0]  = scan_u[k];
                            gnt_rd[0]    = i_req_rd[int'(scan_u[k])*RBITS +: RBITS];
                            gnt_data[0]  = i_req_data[int'(scan_u[k])*XLEN +: XLEN];
                        end else begin
                            gnt_valid[1] = 1'b1;
                            gnt_unit[1]  = scan_u[k];
                            gnt_rd[1]    = i_req_rd[int'(scan_u[k])*RBITS +: RBITS];
                            gnt_data[1]  = i_req_data[int'(scan_u[k])*XLEN +: XLEN];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        last_unit = gnt_valid[1] ? gnt_unit[1] : gnt_unit[0];
        next_ptr  = PW'(wrap_add(int'(last_unit), 1));
        next_rdy  = '0;
        for (int p = 0; p < 2; p++) begin
            if (gnt_valid[p]) next_rdy[gnt_rd[p]] = 1'b1;
        end
    end

    // Flush and reset already suppress gnt_valid, so the pointer and valids need no extra gating
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr     <= '0;
            o_wb_valid <= '0;
            o_wb_rd    <= '0;
            o_wb_data  <= '0;
            o_wb_unit  <= '0;
            o_rdy_regs <= '0;
        end else begin
            o_wb_valid <= gnt_valid;
            o_rdy_regs <= next_rdy;
            for (int p = 0; p < 2; p++) begin
                if (gnt_valid[p]) begin
                    o_wb_rd[p*RBITS +: RBITS] <= gnt_rd[p];
                    o_wb_data[p*XLEN +: XLEN] <= gnt_data[p];
                    o_wb_unit[p*3 +: 3]       <= gnt_unit[p];
                end
            end
            if (|gnt_valid) rr_ptr <= next_ptr;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized scoreboard bench for cdb_arbiter: a queue-based reference model predicts
// ready vectors and broadcasts, and a negedge monitor checks every broadcast cycle.
module tb_cdb_arbiter;

    localparam int UNITS = 5;
    localparam int XLEN  = 32;
    localparam int RBITS = 6;

    logic                   i_clk = 1'b0;
    logic                   i_rst = 1'b0;
    logic                   i_flush = 1'b0;
    logic [UNITS-1:0]       i_req_valid = '0;
    logic [RBITS*UNITS-1:0] i_req_rd = '0;
    logic [XLEN*UNITS-1:0]  i_req_data = '0;
    logic [UNITS-1:0]       o_req_ready;
    logic [1:0]             o_wb_valid;
    logic [2*RBITS-1:0]     o_wb_rd;
    logic [2*XLEN-1:0]      o_wb_data;
    logic [5:0]             o_wb_unit;
    logic [2**RBITS-1:0]    o_rdy_regs;

    cdb_arbiter #(.UNITS(UNITS), .XLEN(XLEN), .RBITS(RBITS)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
        .i_req_valid(i_req_valid), .i_req_rd(i_req_rd), .i_req_data(i_req_data),
        .o_req_ready(o_req_ready), .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd),
        .o_wb_data(o_wb_data), .o_wb_unit(o_wb_unit), .o_rdy_regs(o_rdy_regs)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          due;
        logic [1:0]  v;
        int          unit [2];
        int          rd   [2];
        logic [31:0] data [2];
        logic [63:0] rdy;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          edge_cnt = 0;
    bit          mon_en = 1'b0;
    bit          pend [UNITS];
    int          mrd [UNITS];
    logic [31:0] mdata [UNITS];
    int          rr_m = 0;
    logic [UNITS-1:0] last_ready;

    always @(posedge i_clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Drives the current pending requests for one cycle, predicts the outcome and clocks.
    task automatic applyStimulus(input bit rst, input bit flush);
        exp_t e;
        int winners[$];
        logic [UNITS-1:0] exp_ready;
        i_rst = rst;
        i_flush = flush;
        for (int u = 0; u < UNITS; u++) begin
            i_req_valid[u] = pend[u];
            i_req_rd[u*RBITS +: RBITS] = RBITS'(mrd[u]);
            i_req_data[u*XLEN +: XLEN] = mdata[u];
        end
        #2;
        exp_ready = '0;
        if (!rst && !flush) begin
            // Requesters in order of circular distance from the pointer; first two nonzero-rd win
            for (int d = 0; d < UNITS; d++) begin
                int u;
                u = (rr_m + d) % UNITS;
                if (pend[u] && mrd[u] == 0) exp_ready[u] = 1'b1;
                else if (pend[u] && winners.size() < 2) begin
                    winners.push_back(u);
                    exp_ready[u] = 1'b1;
                end
            end
        end
        checkOutput("req_ready", 64'(o_req_ready), 64'(exp_ready));
        last_ready = o_req_ready;
        if (winners.size() > 0) begin
            e.due = edge_cnt + 1;
            e.v = '0;
            e.rdy = '0;
            for (int p = 0; p < 2; p++) begin
                e.unit[p] = 0;
                e.rd[p] = 0;
                e.data[p] = '0;
            end
            foreach (winners[p]) begin
                e.v[p] = 1'b1;
                e.unit[p] = winners[p];
                e.rd[p] = mrd[winners[p]];
                e.data[p] = mdata[winners[p]];
                e.rdy[mrd[winners[p]]] = 1'b1;
            end
            sb.push_back(e);
        end
        for (int u = 0; u < UNITS; u++) if (exp_ready[u]) pend[u] = 1'b0;
        if (rst) rr_m = 0;
        else if (winners.size() > 0) rr_m = (winners[winners.size()-1] + 1) % UNITS;
        @(posedge i_clk);
        #1;
        if (rst) begin
            checkOutput("rst_wb_valid", 64'(o_wb_valid), 64'd0);
            checkOutput("rst_wb_rd", 64'(o_wb_rd), 64'd0);
            checkOutput("rst_wb_data", 64'(o_wb_data), 64'd0);
            checkOutput("rst_wb_unit", 64'(o_wb_unit), 64'd0);
            checkOutput("rst_rdy_regs", o_rdy_regs, 64'd0);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (mon_en) begin
                if (o_wb_valid !== 2'b00) begin
                    if (sb.size() == 0) begin
                        checkOutput("spurious_wb_valid", 64'(o_wb_valid), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("wb_due", 64'(edge_cnt), 64'(e.due));
                        checkOutput("wb_valid", 64'(o_wb_valid), 64'(e.v));
                        checkOutput("rdy_regs", o_rdy_regs, e.rdy);
                        for (int p = 0; p < 2; p++) begin
                            if (e.v[p]) begin
                                checkOutput("wb_rd", 64'(o_wb_rd[p*RBITS +: RBITS]), 64'(e.rd[p]));
                                checkOutput("wb_data", 64'(o_wb_data[p*XLEN +: XLEN]), 64'(e.data[p]));
                                checkOutput("wb_unit", 64'(o_wb_unit[p*3 +: 3]), 64'(e.unit[p]));
                            end
                        end
                    end
                end else begin
                    checkOutput("idle_rdy_regs", o_rdy_regs, 64'd0);
                    if (sb.size() > 0 && sb[0].due <= edge_cnt) begin
                        e = sb.pop_front();
                        checkOutput("missing_wb_valid", 64'(o_wb_valid), 64'(e.v));
                    end
                end
            end
        end
    end

    task automatic clearRequests();
        for (int u = 0; u < UNITS; u++) begin
            pend[u] = 1'b0;
            mrd[u] = 0;
            mdata[u] = '0;
        end
    endtask

    task automatic loadAll();
        for (int u = 0; u < UNITS; u++) begin
            pend[u] = 1'b1;
            mrd[u] = u + 1;
            mdata[u] = 32'hA000_0000 + 32'(u);
        end
    endtask

    initial begin
        logic [UNITS-1:0] rot_tbl [4];
        int guard;
        rot_tbl[0] = 5'b00011;
        rot_tbl[1] = 5'b01100;
        rot_tbl[2] = 5'b10001;
        rot_tbl[3] = 5'b00110;
        clearRequests();
        #1;

        applyStimulus(1, 0);
        mon_en = 1'b1;
        applyStimulus(1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0);

        pend[2] = 1'b1; mrd[2] = 17; mdata[2] = 32'hDEADBEEF;
        applyStimulus(0, 0);
        checkOutput("single_ready", 64'(last_ready), 64'h04);
        applyStimulus(0, 0);
        applyStimulus(0, 0);

        applyStimulus(1, 0);
        for (int c = 0; c < 4; c++) begin
            loadAll();
            applyStimulus(0, 0);
            checkOutput("rotation_ready", 64'(last_ready), 64'(rot_tbl[c]));
        end

        clearRequests();
        applyStimulus(1, 0);
        pend[0] = 1'b1; mrd[0] = 0; mdata[0] = 32'h1111;
        pend[1] = 1'b1; mrd[1] = 0; mdata[1] = 32'h2222;
        pend[3] = 1'b1; mrd[3] = 9; mdata[3] = 32'h3333;
        applyStimulus(0, 0);
        checkOutput("rd0_mix_ready", 64'(last_ready), 64'h0B);
        applyStimulus(0, 0);

        loadAll();
        applyStimulus(0, 0);
        loadAll();
        applyStimulus(0, 1);
        checkOutput("flush_ready", 64'(last_ready), 64'd0);
        applyStimulus(0, 0);
        loadAll();
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        checkOutput("post_reset_ready", 64'(last_ready), 64'h03);

        clearRequests();
        applyStimulus(1, 0);
        pend[1] = 1'b1; mrd[1] = 40; mdata[1] = 32'h0000_0401;
        pend[4] = 1'b1; mrd[4] = 40; mdata[4] = 32'h0000_0404;
        applyStimulus(0, 0);
        checkOutput("dup_rd_ready", 64'(last_ready), 64'h12);
        loadAll();
        applyStimulus(0, 0);
        checkOutput("dup_rd_wrap_ready", 64'(last_ready), 64'h03);

        for (int c = 0; c < 500; c++) begin
            for (int u = 0; u < UNITS; u++) begin
                if (!pend[u] && $urandom_range(0, 99) < 60) begin
                    pend[u] = 1'b1;
                    mrd[u] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 63));
                    mdata[u] = $urandom;
                end
            end
            applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6);
        end

        guard = 0;
        while ((pend[0] || pend[1] || pend[2] || pend[3] || pend[4]) && guard < 10) begin
            applyStimulus(0, 0);
            guard++;
        end
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
